// File: rtl/telemetry_counter_gen.sv
// -----------------------------------------------------------------------------
// telemetry_counter_gen
//
// Transmit-side test source for the stream-0xD telemetry counter link. A free
// running timer produces one tick every g_period cycles while enabled. Each
// tick loads an 88-bit packet carrying a wrapping 10-bit counter and a 32-bit
// sequence number, presented over a valid/ready handshake. Two pulse inputs
// let the far-end checker be exercised: inject_drop skips one counter value,
// inject_corrupt flips bit 0 of the counter in one presented packet.
//
// Ports
//   i_clk_256M        in   1   single clock, rising edge
//   i_reset           in   1   synchronous, active-high, overrides everything
//   i_enable          in   1   1 = generate ticks; 0 = no new packets
//   i_packet_ready    in   1   downstream accepts when valid & ready
//   i_inject_drop     in   1   pulse: next accepted packet advances cnt by 2
//   i_inject_corrupt  in   1   pulse: next presented packet has cnt[0] flipped
//   o_packet_data     out  88  {4'h0, stream_id, 38'h0, seq[31:0], cnt[9:0]}
//   o_packet_valid    out  1   held until accepted
//   o_sent_count      out  32  accepted packets since reset (wraps)
//   o_overrun_count   out  16  ticks discarded while a packet was pending (saturates)
// -----------------------------------------------------------------------------
module telemetry_counter_gen #(
  parameter logic [15:0] g_period    = 16'd410,
  parameter logic [3:0]  g_stream_id = 4'hD,
  parameter logic [9:0]  g_cnt_init  = 10'd0
) (
  input  logic        i_clk_256M,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_packet_ready,
  input  logic        i_inject_drop,
  input  logic        i_inject_corrupt,
  output logic [87:0] o_packet_data,
  output logic        o_packet_valid,
  output logic [31:0] o_sent_count,
  output logic [15:0] o_overrun_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic [9:0]  r_cnt;
  logic        r_drop_flag;
  logic        r_corrupt_flag;
  logic        r_pkt_corrupt;   // the packet currently held was built corrupted
  logic [87:0] r_packet_data;
  logic        r_packet_valid;
  logic [31:0] r_sent_count;
  logic [15:0] r_overrun_count;

  logic        w_tick;
  logic        w_accept;
  logic        w_load;
  logic        w_overrun;
  logic [9:0]  w_cnt_nxt;
  logic [31:0] w_sent_nxt;
  logic        w_corrupt_eff;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // Modulo-1024 advance; a pending drop skips one value.
  function automatic logic [9:0] cnt_advance(input logic [9:0] cnt, input logic drop);
    return cnt + (drop ? 10'd2 : 10'd1);
  endfunction

  function automatic logic [87:0] pack(input logic [9:0] cnt, input logic [31:0] seq);
    return {4'h0, g_stream_id, 38'h0, seq, cnt};
  endfunction

  assign w_tick    = i_enable && (r_timer == (g_period - 16'd1));
  assign w_accept  = (r_state == ST_SEND) && i_packet_ready;
  assign w_load    = w_tick && ((r_state == ST_IDLE) || w_accept);
  assign w_overrun = w_tick && (r_state == ST_SEND) && !w_accept;

  // A load coincident with an accept sees the post-accept counter and count,
  // so back-to-back packets stay in sequence.
  assign w_cnt_nxt  = w_accept ? cnt_advance(r_cnt, r_drop_flag) : r_cnt;
  assign w_sent_nxt = w_accept ? r_sent_count + 32'd1 : r_sent_count;

  // The corrupt request is consumed by the accept of the packet it corrupted;
  // until then further pulses merge into it. A fresh pulse always arms it.
  assign w_corrupt_eff = (r_corrupt_flag & ~(w_accept & r_pkt_corrupt)) | i_inject_corrupt;

  always_ff @(posedge i_clk_256M) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_timer         <= 16'd0;
      r_cnt           <= g_cnt_init;
      r_drop_flag     <= 1'b0;
      r_corrupt_flag  <= 1'b0;
      r_pkt_corrupt   <= 1'b0;
      r_packet_data   <= 88'h0;
      r_packet_valid  <= 1'b0;
      r_sent_count    <= 32'd0;
      r_overrun_count <= 16'd0;
    end else begin
      // Timer holds at zero while disabled so the first tick is g_period
      // cycles after enable rises.
      if (!i_enable || w_tick) r_timer <= 16'd0;
      else                     r_timer <= r_timer + 16'd1;

      r_cnt          <= w_cnt_nxt;
      r_sent_count   <= w_sent_nxt;
      r_corrupt_flag <= w_corrupt_eff;
      // A drop pulse arriving with an accept targets the following packet.
      r_drop_flag    <= w_accept ? i_inject_drop : (r_drop_flag | i_inject_drop);

      if (w_overrun) r_overrun_count <= sat_inc16(r_overrun_count);

      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_packet_data  <= pack(w_cnt_nxt ^ {9'b0, w_corrupt_eff}, w_sent_nxt);
            r_pkt_corrupt  <= w_corrupt_eff;
            r_packet_valid <= 1'b1;
            r_state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_load) begin
            r_packet_data  <= pack(w_cnt_nxt ^ {9'b0, w_corrupt_eff}, w_sent_nxt);
            r_pkt_corrupt  <= w_corrupt_eff;
            r_packet_valid <= 1'b1;
            r_state        <= ST_SEND;
          end else if (w_accept) begin
            r_packet_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_packet_valid <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_packet_data   = r_packet_data;
  assign o_packet_valid  = r_packet_valid;
  assign o_sent_count    = r_sent_count;
  assign o_overrun_count = r_overrun_count;

endmodule

// File: tb/tb_telemetry_counter_gen.sv
module tb_telemetry_counter_gen;

  localparam int          P    = 8;
  localparam logic [9:0]  INIT = 10'h3F8;   // close to the wrap point
  localparam logic [3:0]  SID  = 4'hD;

  logic        clk = 1'b0;
  logic        rst, en, rdy, idrop, icorr;
  logic [87:0] o_packet_data;
  logic        o_packet_valid;
  logic [31:0] o_sent_count;
  logic [15:0] o_overrun_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  telemetry_counter_gen #(
    .g_period   (16'(P)),
    .g_stream_id(SID),
    .g_cnt_init (INIT)
  ) dut (
    .i_clk_256M      (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_packet_ready  (rdy),
    .i_inject_drop   (idrop),
    .i_inject_corrupt(icorr),
    .o_packet_data   (o_packet_data),
    .o_packet_valid  (o_packet_valid),
    .o_sent_count    (o_sent_count),
    .o_overrun_count (o_overrun_count)
  );

  // Reference model: plain integers following the link's rules.
  int          m_timer;
  bit          m_valid;
  int          m_cnt;          // true counter value, 0..1023
  logic [31:0] m_sent;
  int          m_ovr;
  bit          m_drop;
  int          m_corr;         // 0 = none, 1 = armed, 2 = corrupted packet in flight
  logic [87:0] m_data;

  task automatic model_reset();
    m_timer = 0; m_valid = 0; m_cnt = int'(INIT); m_sent = 0;
    m_ovr = 0; m_drop = 0; m_corr = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit tick, accept, load, corrupted;
    logic [9:0] shown;
    if (rst) begin
      model_reset();
      return;
    end
    tick   = en && (m_timer == P - 1);
    accept = m_valid && rdy;
    load   = tick && (!m_valid || accept);
    if (tick && m_valid && !accept && m_ovr < 65535) m_ovr++;
    if (accept) begin
      m_cnt  = (m_cnt + (m_drop ? 2 : 1)) % 1024;
      m_drop = 0;
      m_sent = m_sent + 1;
      if (m_corr == 2) m_corr = 0;
    end
    if (idrop) m_drop = 1;
    if (icorr && m_corr == 0) m_corr = 1;
    if (load) begin
      corrupted = (m_corr == 1);
      if (corrupted) m_corr = 2;
      shown   = 10'(m_cnt) ^ {9'b0, corrupted};
      m_data  = {4'h0, SID, 38'h0, m_sent, shown};
      m_valid = 1;
    end else if (accept) begin
      m_valid = 0;
    end
    m_timer = en ? (tick ? 0 : m_timer + 1) : 0;
  endtask

  task automatic check();
    n_tests++;
    assert (o_packet_valid === m_valid) else begin
      n_fail++;
      $error("FAIL valid t=%0t got %0b exp %0b", $time, o_packet_valid, m_valid);
    end
    n_tests++;
    assert (o_packet_data === m_data) else begin
      n_fail++;
      $error("FAIL data t=%0t got %h exp %h", $time, o_packet_data, m_data);
    end
    n_tests++;
    assert (o_sent_count === m_sent) else begin
      n_fail++;
      $error("FAIL sent_count t=%0t got %0d exp %0d", $time, o_sent_count, m_sent);
    end
    n_tests++;
    assert (o_overrun_count === 16'(m_ovr)) else begin
      n_fail++;
      $error("FAIL overrun_count t=%0t got %0d exp %0d", $time, o_overrun_count, m_ovr);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rd,
                      input logic d, input logic c);
    rst = r; en = e; rdy = rd; idrop = d; icorr = c;
    @(posedge clk);
    model_step();
    #1;
    check();
  endtask

  // Hold ready low until a packet is presented; bounded by a cycle budget.
  task automatic wait_valid(input logic e);
    bit seen;
    seen = 0;
    for (int k = 0; k < 4 * P && !seen; k++) begin
      step(1'b0, e, 1'b0, 1'b0, 1'b0);
      seen = o_packet_valid;
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL wait_valid t=%0t got valid=%0b exp 1", $time, o_packet_valid);
    end
  endtask

  initial begin
    rst = 1; en = 0; rdy = 0; idrop = 0; icorr = 0;
    model_reset();

    // Reset state
    repeat (3) step(1, 0, 0, 0, 0);

    // Free-running stream with ready high, crossing the 3FF->000 wrap
    repeat (30 * P) step(0, 1, 1, 0, 0);

    // Drop pulse while a packet is pending, then a doubled drop pulse
    wait_valid(1);
    step(0, 1, 0, 1, 0);
    repeat (3 * P) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    repeat (3 * P) step(0, 1, 1, 0, 0);

    // Corrupt pulse in idle, then one coincident with a load
    step(0, 1, 1, 0, 1);
    repeat (3 * P) step(0, 1, 1, 0, 0);
    wait_valid(1);
    repeat (P - 1) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    repeat (3 * P) step(0, 1, 1, 0, 0);

    // Backpressure: three overruns, then two more, then drain
    repeat (3 * P) step(0, 1, 0, 0, 0);
    repeat (2 * P) step(0, 1, 0, 0, 0);
    repeat (4 * P) step(0, 1, 1, 0, 0);

    // Enable falls while a packet is pending: it still completes
    wait_valid(1);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (4 * P) step(0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(0,
           logic'($urandom_range(0, 199) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 39) == 0));
    end

    // Reset while a packet is pending, then restart
    wait_valid(1);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (3 * P) step(0, 1, 1, 0, 0);

    // Reset while disabled, then restart
    repeat (2) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (3 * P) step(0, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
